// File: rtl/wb_block_writer.sv
// wb_block_writer: register-file write-back sequencer for block loads plus single write-backs
module wb_block_writer #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_REGS-1:0] reg_list,
  input  logic                data_valid,
  input  logic [DATA_W-1:0]   data_in,
  output logic                data_ready,
  input  logic                single_wb_en,
  input  logic [3:0]          single_dest,
  input  logic [DATA_W-1:0]   single_result,
  output logic                writeBackEn,
  output logic [3:0]          Dest_wb,
  output logic [DATA_W-1:0]   Result_WB,
  output logic                busy,
  output logic                done,
  output logic [NUM_REGS-1:0] pending_mask
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
  state_t state, state_nxt;
  logic accept;
  logic [NUM_REGS-1:0] mask_rest;
  function automatic logic [3:0] lowest(input logic [NUM_REGS-1:0] m);
    lowest = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) if (m[i]) lowest = 4'(i);
  endfunction
  // beat handshake, status flags and next state
  always_comb begin
    data_ready = (state == XFER) && !single_wb_en;
    accept     = data_ready && data_valid;
    mask_rest  = pending_mask & (pending_mask - 1'b1);
    busy       = state != IDLE;
    done       = state == DONE;
    state_nxt  = state;
    case (state)
      IDLE:    state_nxt = start ? ((reg_list != '0) ? XFER : DONE) : IDLE;
      XFER:    state_nxt = (accept && mask_rest == '0) ? DONE : XFER;
      default: state_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // outstanding register list, lowest bit retired per accepted beat
  always_ff @(posedge clk or negedge rst)
    if (!rst) pending_mask <= '0;
    else if (state == IDLE && start) pending_mask <= reg_list;
    else if (accept) pending_mask <= mask_rest;
  // write port: single write-back wins, otherwise the accepted beat
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      writeBackEn <= 1'b0;
      Dest_wb     <= '0;
      Result_WB   <= '0;
    end else begin
      writeBackEn <= single_wb_en || accept;
      if (single_wb_en) begin
        Dest_wb   <= single_dest;
        Result_WB <= single_result;
      end else if (accept) begin
        Dest_wb   <= lowest(pending_mask);
        Result_WB <= data_in;
      end
    end
endmodule

// File: tb/tb_wb_block_writer.sv
// tb_wb_block_writer: randomized and directed check of wb_block_writer against a queue-based model
module tb_wb_block_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [14:0] reg_list = '0;
  logic        data_valid = 1'b0;
  logic [31:0] data_in = '0;
  logic        data_ready;
  logic        single_wb_en = 1'b0;
  logic [3:0]  single_dest = '0;
  logic [31:0] single_result = '0;
  logic        writeBackEn;
  logic [3:0]  Dest_wb;
  logic [31:0] Result_WB;
  logic        busy;
  logic        done;
  logic [14:0] pending_mask;
  int compared = 0;
  int mismatched = 0;
  int mq[$];
  int m_st = 0;
  logic [3:0]  m_dest = '0;
  logic [31:0] m_res = '0;
  wb_block_writer dut (
    .clk(clk), .rst(rst), .start(start), .reg_list(reg_list),
    .data_valid(data_valid), .data_in(data_in), .data_ready(data_ready),
    .single_wb_en(single_wb_en), .single_dest(single_dest), .single_result(single_result),
    .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .Result_WB(Result_WB),
    .busy(busy), .done(done), .pending_mask(pending_mask)
  );
  always #5 clk = ~clk;
  function automatic void chk(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction
  function automatic logic [14:0] model_mask();
    logic [14:0] m = '0;
    foreach (mq[i]) m[mq[i]] = 1'b1;
    return m;
  endfunction
  task automatic quiet();
    start = 0; reg_list = '0; data_valid = 0; data_in = '0;
    single_wb_en = 0; single_dest = '0; single_result = '0;
  endtask
  task automatic step();
    bit rdy, acc, we;
    #1 rdy = (m_st == 1) && !single_wb_en;
    chk("data_ready", 64'(data_ready), 64'(rdy));
    acc = rdy && data_valid;
    we = single_wb_en || acc;
    if (single_wb_en) begin m_dest = single_dest; m_res = single_result; end
    else if (acc) begin m_dest = 4'(mq[0]); m_res = data_in; end
    if (m_st == 0) begin
      if (start) begin
        for (int i = 0; i < 15; i++) if (reg_list[i]) mq.push_back(i);
        m_st = (mq.size() != 0) ? 1 : 2;
      end
    end else if (m_st == 1) begin
      if (acc) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_st = 2;
      end
    end else m_st = 0;
    @(posedge clk);
    #1;
    chk("writeBackEn", 64'(writeBackEn), 64'(we));
    chk("Dest_wb", 64'(Dest_wb), 64'(m_dest));
    chk("Result_WB", 64'(Result_WB), 64'(m_res));
    chk("busy", 64'(busy), 64'(m_st != 0));
    chk("done", 64'(done), 64'(m_st == 2));
    chk("pending_mask", 64'(pending_mask), 64'(model_mask()));
    @(negedge clk);
  endtask
  task automatic begin_block(input logic [14:0] l);
    start = 1; reg_list = l;
    step();
    start = 0; reg_list = '0;
  endtask
  task automatic beat(input logic [31:0] d);
    data_valid = 1; data_in = d;
    step();
    data_valid = 0;
  endtask
  initial begin
    quiet();
    @(negedge clk);
    @(negedge clk);
    chk("reset_wbe", 64'(writeBackEn), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_mask", 64'(pending_mask), 64'd0);
    chk("reset_ready", 64'(data_ready), 64'd0);
    rst = 1;
    step();
    begin_block(15'h0015);
    beat(32'hA1); beat(32'hA2); beat(32'hA3);
    step(); step();
    begin_block(15'h0000);
    step(); step();
    begin_block(15'h0003);
    data_valid = 1; data_in = 32'hB1;
    single_wb_en = 1; single_dest = 4'd7; single_result = 32'hDEAD;
    step();
    single_wb_en = 0;
    step();
    beat(32'hB2);
    step(); step();
    begin_block(15'h4000);
    repeat (5) step();
    beat(32'hC1);
    step(); step();
    begin_block(15'h00FF);
    beat(32'hD1); beat(32'hD2); beat(32'hD3);
    data_valid = 1; data_in = 32'hD4;
    #2 rst = 0;
    #1;
    chk("async_mask", 64'(pending_mask), 64'd0);
    chk("async_wbe", 64'(writeBackEn), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_dest", 64'(Dest_wb), 64'd0);
    mq.delete(); m_st = 0; m_dest = '0; m_res = '0;
    @(negedge clk);
    rst = 1;
    repeat (3) step();
    data_valid = 0;
    begin_block(15'h0006);
    start = 1; reg_list = 15'h0001;
    beat(32'hE1);
    beat(32'hE2);
    start = 0; reg_list = '0;
    step(); step();
    for (int n = 0; n < 400; n++) begin
      start = ($urandom_range(0, 5) == 0);
      reg_list = ($urandom_range(0, 7) == 0) ? 15'h0 : 15'($urandom);
      data_valid = $urandom_range(0, 2) != 0;
      data_in = $urandom;
      single_wb_en = ($urandom_range(0, 3) == 0);
      single_dest = 4'($urandom);
      single_result = $urandom;
      step();
    end
    quiet();
    repeat (40) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
